// File: rtl/input_buf_pkg.sv
// input_buf_pkg: shared widths and enums for the ifmap input-buffer loader
package input_buf_pkg;
  localparam int OFF_W  = $clog2(1176);
  localparam int BNK_W  = $clog2(25);
  localparam int CNT_W  = $clog2(1176 + 1);
  localparam int BCNT_W = $clog2(25 + 1);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} load_state_t;
  typedef enum logic {BANK_MAJOR, ROUND_ROBIN} load_mode_t;
endpackage

// File: rtl/buff_addr_gen.sv
// buff_addr_gen: latched load config plus bank/offset/beat counters with mode-dependent wrap
module buff_addr_gen
  import input_buf_pkg::*;
#(
  parameter int SRAM_DEPTH = 1176,
  parameter int BAND_WIDTH = 25,
  localparam int OW = $clog2(SRAM_DEPTH),
  localparam int BW = $clog2(BAND_WIDTH),
  localparam int CW = $clog2(SRAM_DEPTH + 1),
  localparam int BCW = $clog2(BAND_WIDTH + 1),
  localparam int TW = $clog2(SRAM_DEPTH * BAND_WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  load_mode_t     mode_i,
  input  logic [BCW-1:0] bank_cnt_i,
  input  logic [CW-1:0]  wpb_i,
  input  logic           beat_i,
  output logic [BW-1:0]  bank_o,
  output logic [OW-1:0]  off_o,
  output logic           last_o
);
  load_mode_t     mode_q;
  logic [BCW-1:0] bcnt_q;
  logic [CW-1:0]  wpb_q;
  logic [TW-1:0]  total_q, beat_q;
  logic [BW-1:0]  bank_q;
  logic [OW-1:0]  off_q;
  logic           off_end, bank_end;
  assign off_end  = CW'(off_q) == wpb_q - CW'(1);
  assign bank_end = BCW'(bank_q) == bcnt_q - BCW'(1);
  assign bank_o   = bank_q;
  assign off_o    = off_q;
  assign last_o   = beat_q == total_q - TW'(1);
  // config is captured only on an accepted start; counters advance one step per beat
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= BANK_MAJOR;
      bcnt_q  <= '0;
      wpb_q   <= '0;
      total_q <= '0;
      beat_q  <= '0;
      bank_q  <= '0;
      off_q   <= '0;
    end else if (load_i) begin
      mode_q  <= mode_i;
      bcnt_q  <= bank_cnt_i;
      wpb_q   <= wpb_i;
      total_q <= TW'(bank_cnt_i) * TW'(wpb_i);
      beat_q  <= '0;
      bank_q  <= '0;
      off_q   <= '0;
    end else if (beat_i) begin
      beat_q <= beat_q + TW'(1);
      if (mode_q == ROUND_ROBIN) begin
        bank_q <= bank_end ? '0 : bank_q + BW'(1);
        off_q  <= bank_end ? off_q + OW'(1) : off_q;
      end else begin
        off_q  <= off_end ? '0 : off_q + OW'(1);
        bank_q <= off_end ? bank_q + BW'(1) : bank_q;
      end
    end
  end
endmodule

// File: rtl/ifmap_buff_loader.sv
// ifmap_buff_loader: turns a valid/ready byte stream into banked input-SRAM write strobes
module ifmap_buff_loader
  import input_buf_pkg::*;
#(
  parameter int SRAM_DEPTH = 1176,
  parameter int BAND_WIDTH = 25,
  parameter int DATA_WIDTH = 8,
  localparam int OW = $clog2(SRAM_DEPTH),
  localparam int BW = $clog2(BAND_WIDTH),
  localparam int CW = $clog2(SRAM_DEPTH + 1),
  localparam int BCW = $clog2(BAND_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [BCW-1:0]        bank_cnt_i,
  input  logic [CW-1:0]         words_per_bank_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  wea_o,
  output logic [BW+OW-1:0]      addra_o,
  output logic [DATA_WIDTH-1:0] dia_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  cfg_err_o
);
  load_state_t   state_q, state_d;
  logic          cfg_ok, idle, go, beat, last;
  logic [BW-1:0] bank;
  logic [OW-1:0] off;
  assign cfg_ok = bank_cnt_i != '0 && bank_cnt_i <= BCW'(BAND_WIDTH) &&
                  words_per_bank_i != '0 && words_per_bank_i <= CW'(SRAM_DEPTH);
  assign idle   = state_q == IDLE;
  assign go     = idle && start_i && cfg_ok;
  assign beat   = s_valid_i && s_ready_o;
  buff_addr_gen #(.SRAM_DEPTH(SRAM_DEPTH), .BAND_WIDTH(BAND_WIDTH)) u_addr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (go),
    .mode_i    (load_mode_t'(mode_i)),
    .bank_cnt_i(bank_cnt_i),
    .wpb_i     (words_per_bank_i),
    .beat_i    (beat),
    .bank_o    (bank),
    .off_o     (off),
    .last_o    (last)
  );
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // next state: the last accepted beat moves to FLUSH so its write can drain
  always_comb state_d = idle ? (go ? LOAD : IDLE) :
                        state_q == LOAD ? ((beat && last) ? FLUSH : LOAD) : IDLE;
  // stream is only accepted while loading
  always_comb s_ready_o = state_q == LOAD;
  // registered write strobe one cycle after each beat, plus status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wea_o       <= 1'b0;
      addra_o     <= '0;
      dia_o       <= '0;
      busy_o      <= 1'b0;
      load_done_o <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      wea_o       <= beat;
      addra_o     <= beat ? {bank, off} : addra_o;
      dia_o       <= beat ? s_data_i : dia_o;
      busy_o      <= go || (busy_o && !load_done_o);
      load_done_o <= state_q == FLUSH;
      cfg_err_o   <= idle && start_i && !cfg_ok;
    end
  end
endmodule

// File: tb/tb_ifmap_buff_loader.sv
// tb_ifmap_buff_loader: randomized self-checking bench against an element-index address model
module tb_ifmap_buff_loader;
  localparam int SD = 1176, BW = 25;
  logic        clk = 1'b0, rst, start_i, mode_i, s_valid_i;
  logic [4:0]  bank_cnt_i;
  logic [10:0] words_per_bank_i;
  logic [7:0]  s_data_i, dia_o;
  logic        s_ready_o, wea_o, busy_o, load_done_o, cfg_err_o;
  logic [15:0] addra_o;
  int vecs = 0, errs = 0;
  bit m_ld, m_post, m_busy, m_wea, m_done, m_err, m_mode, track;
  int m_k, m_tot, m_bc, m_wpb, m_addr, m_dia, dups, nwr;
  bit seen [65536];

  ifmap_buff_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .bank_cnt_i(bank_cnt_i),
    .words_per_bank_i(words_per_bank_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_o), .wea_o(wea_o), .addra_o(addra_o), .dia_o(dia_o),
    .busy_o(busy_o), .load_done_o(load_done_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int addr_of(int k);
    return m_mode ? (((k % m_bc) << 11) | (k / m_bc)) : (((k / m_wpb) << 11) | (k % m_wpb));
  endfunction

  task automatic step();
    bit old_ld = m_ld, old_post = m_post, old_done = m_done;
    @(posedge clk);
    if (rst) begin
      {m_ld, m_post, m_busy, m_wea, m_done, m_err} = '0;
      m_addr = 0;
      m_dia = 0;
    end else begin
      m_wea = 0;
      m_err = 0;
      m_done = old_post;
      m_post = 0;
      if (old_done) m_busy = 0;
      if (old_ld && s_valid_i) begin
        m_wea = 1;
        m_addr = addr_of(m_k);
        m_dia = s_data_i;
        m_k++;
        if (m_k == m_tot) begin
          m_ld = 0;
          m_post = 1;
        end
      end
      if (!old_ld && !old_post && start_i) begin
        if (bank_cnt_i >= 1 && bank_cnt_i <= BW && words_per_bank_i >= 1 && words_per_bank_i <= SD) begin
          m_ld = 1;
          m_k = 0;
          m_bc = bank_cnt_i;
          m_wpb = words_per_bank_i;
          m_mode = mode_i;
          m_tot = m_bc * m_wpb;
          m_busy = 1;
        end else m_err = 1;
      end
    end
    #1;
    check("s_ready", s_ready_o, m_ld);
    check("wea", wea_o, m_wea);
    check("addra", addra_o, m_addr);
    check("dia", dia_o, m_dia);
    check("busy", busy_o, m_busy);
    check("load_done", load_done_o, m_done);
    check("cfg_err", cfg_err_o, m_err);
    if (track && wea_o === 1'b1) begin
      if (seen[addra_o]) dups++;
      seen[addra_o] = 1;
      nwr++;
    end
  endtask

  task automatic idle_cycles(input int n);
    start_i = 0;
    s_valid_i = 0;
    rst = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(input bit mode, input int bc, input int wpb);
    start_i = 1;
    mode_i = mode;
    bank_cnt_i = 5'(bc);
    words_per_bank_i = 11'(wpb);
    s_valid_i = 0;
    step();
    start_i = 0;
  endtask

  task automatic run_load(input bit mode, input int bc, input int wpb, input int gap,
                          input logic [7:0] base, input int poke);
    int cyc = 0;
    do_start(mode, bc, wpb);
    while ((m_ld || m_post || m_done) && cyc < 200000) begin
      s_valid_i = $urandom_range(99) >= gap;
      s_data_i = base + 8'(m_k);
      start_i = cyc == poke;
      mode_i = (cyc == poke) ? ~mode : 1'($urandom);
      bank_cnt_i = (cyc == poke) ? 5'd1 : 5'($urandom);
      words_per_bank_i = (cyc == poke) ? 11'd1 : 11'($urandom);
      step();
      cyc++;
    end
    if (cyc >= 200000) check("load_timeout", 1, 0);
    start_i = 0;
    s_valid_i = 0;
  endtask

  initial begin
    rst = 1;
    start_i = 0;
    mode_i = 0;
    bank_cnt_i = 0;
    words_per_bank_i = 0;
    s_valid_i = 0;
    s_data_i = 0;
    track = 0;
    step();
    step();
    idle_cycles(2);
    run_load(0, 2, 3, 0, 8'h10, -1);
    run_load(1, 3, 2, 0, 8'hA0, -1);
    do_start(0, 0, 3);
    idle_cycles(2);
    do_start(0, 2, 1177);
    idle_cycles(2);
    run_load(0, 1, 1, 0, 8'h5A, -1);
    do_start(0, 2, 3);
    s_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      s_data_i = 8'h20 + 8'(i);
      step();
    end
    rst = 1;
    s_valid_i = 0;
    step();
    idle_cycles(2);
    run_load(0, 2, 3, 0, 8'h30, -1);
    run_load(1, 4, 3, 20, 8'h70, 3);
    for (int i = 0; i < 6; i++)
      run_load(1'($urandom), $urandom_range(1, BW), $urandom_range(1, 40), $urandom_range(0, 50),
               8'($urandom), -1);
    dups = 0;
    nwr = 0;
    track = 1;
    run_load(0, BW, SD, 30, 8'h00, -1);
    track = 0;
    check("full_writes", nwr, BW * SD);
    check("full_dups", dups, 0);
    check("full_last_addr", addra_o, (24 << 11) | 1175);
    idle_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
